// File: rtl/ball_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ball_pkg
//  Purpose  : Shared state encoding, map codes, screen limits and tilt decode
//             for the ball move controller.
//  Revision : 1.0  initial release
// ============================================================================
package ball_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ_X  = 3'd1,
        ST_WAIT_X = 3'd2,
        ST_REQ_Y  = 3'd3,
        ST_WAIT_Y = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam logic [7:0] WALL_CODE = 8'd2;
    localparam logic [7:0] GOAL_CODE = 8'd3;

    localparam int DEF_COL_MAX = 639;
    localparam int DEF_ROW_MAX = 479;

    localparam logic [1:0] DIR_ZERO = 2'b00;
    localparam logic [1:0] DIR_POS  = 2'b01;
    localparam logic [1:0] DIR_NEG  = 2'b10;

    function automatic logic [1:0] tilt_dir(input logic [8:0] tilt, input int hi, input int lo);
        if (int'(tilt) >= hi) return DIR_POS;
        if (int'(tilt) <= lo) return DIR_NEG;
        return DIR_ZERO;
    endfunction

endpackage
`default_nettype wire

// File: rtl/update_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : update_tick_gen
//  Purpose  : Free-running divider producing a one-cycle move-update tick;
//             SIMULATE selects a short period for simulation.
//  Revision : 1.0  initial release
// ============================================================================
module update_tick_gen #(
    parameter int CLK_FREQUENCY_HZ       = 100000000,
    parameter int UPDATE_FREQUENCY_HZ    = 5,
    parameter int SIMULATE               = 0,
    parameter int SIMULATE_FREQUENCY_CNT = 5
) (
    input  logic clk,
    input  logic reset,
    output logic o_tick
);

    localparam int c_real_top = CLK_FREQUENCY_HZ / UPDATE_FREQUENCY_HZ - 1;
    localparam int c_top_max  = (c_real_top > SIMULATE_FREQUENCY_CNT) ? c_real_top
                                                                      : SIMULATE_FREQUENCY_CNT;
    localparam int c_cnt_w    = (c_top_max > 0) ? $clog2(c_top_max + 1) : 1;

    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_top;

    generate
        if (SIMULATE != 0) begin : g_sim_top
            assign w_top = c_cnt_w'(SIMULATE_FREQUENCY_CNT);
        end else begin : g_real_top
            assign w_top = c_cnt_w'(c_real_top);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_cnt == w_top) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    assign o_tick = (r_cnt == w_top);

endmodule
`default_nettype wire

// File: rtl/ball_move_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ball_move_ctrl
//  Purpose  : Turns tilt into wall-checked one-step ball moves via the shared
//             map read port. Optional goal lock: BALL_GOAL_DETECT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module ball_move_ctrl
    import ball_pkg::*;
#(
    parameter int CLK_FREQUENCY_HZ       = 100000000,
    parameter int UPDATE_FREQUENCY_HZ    = 5,
    parameter int SIMULATE               = 0,
    parameter int SIMULATE_FREQUENCY_CNT = 5,
    parameter int HI_THRESH              = 400,
    parameter int LO_THRESH              = 100,
    parameter int STEP                   = 1,
    parameter int COL_MAX                = DEF_COL_MAX,
    parameter int ROW_MAX                = DEF_ROW_MAX,
    parameter int START_COL              = 0,
    parameter int START_ROW              = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] accel_x,
    input  logic [8:0] accel_y,
    output logic       map_req,
    input  logic       map_gnt,
    output logic [9:0] map_col_addr,
    output logic [8:0] map_row_addr,
    input  logic [7:0] map_loc_info,
    output logic [9:0] pos_col,
    output logic [8:0] pos_row,
    output logic       busy,
    output logic       move_done,
    output logic       goal_reached
);

    localparam logic [10:0] c_col_step = 11'(STEP);
    localparam logic [9:0]  c_row_step = 10'(STEP);
    localparam logic [10:0] c_col_max  = 11'(COL_MAX);
    localparam logic [9:0]  c_row_max  = 10'(ROW_MAX);

    logic        w_tick;
    logic [1:0]  w_dir_x;
    logic [1:0]  w_dir_y;
    logic [10:0] w_cand_col;
    logic [9:0]  w_cand_row;
    logic        w_x_ok;
    logic        w_y_ok;
    logic        w_accept;
    logic        w_is_goal;
    logic [9:0]  w_col_next;

    state_t      r_state;
    logic [9:0]  r_cand_col;
    logic [8:0]  r_cand_row;
    logic        r_y_ok;
    logic        r_goal_hit;
    logic        r_locked;

    update_tick_gen #(
        .CLK_FREQUENCY_HZ       (CLK_FREQUENCY_HZ),
        .UPDATE_FREQUENCY_HZ    (UPDATE_FREQUENCY_HZ),
        .SIMULATE               (SIMULATE),
        .SIMULATE_FREQUENCY_CNT (SIMULATE_FREQUENCY_CNT)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .o_tick (w_tick)
    );

    assign w_dir_x = tilt_dir(accel_x, HI_THRESH, LO_THRESH);
    assign w_dir_y = tilt_dir(accel_y, HI_THRESH, LO_THRESH);

    // One extra bit so a step below 0 wraps high and fails the upper-bound test.
    always_comb begin
        w_cand_col = {1'b0, pos_col};
        w_cand_row = {1'b0, pos_row};
        if (w_dir_x == DIR_POS)      w_cand_col = {1'b0, pos_col} + c_col_step;
        else if (w_dir_x == DIR_NEG) w_cand_col = {1'b0, pos_col} - c_col_step;
        if (w_dir_y == DIR_POS)      w_cand_row = {1'b0, pos_row} + c_row_step;
        else if (w_dir_y == DIR_NEG) w_cand_row = {1'b0, pos_row} - c_row_step;
    end

    assign w_x_ok     = (w_dir_x != DIR_ZERO) && (w_cand_col <= c_col_max);
    assign w_y_ok     = (w_dir_y != DIR_ZERO) && (w_cand_row <= c_row_max);
    assign w_accept   = (map_loc_info != WALL_CODE);
    assign w_col_next = w_accept ? r_cand_col : pos_col;

`ifdef BALL_GOAL_DETECT_EN
    assign w_is_goal = (map_loc_info == GOAL_CODE);
`else
    assign w_is_goal = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_cand_col   <= '0;
            r_cand_row   <= '0;
            r_y_ok       <= 1'b0;
            r_goal_hit   <= 1'b0;
            r_locked     <= 1'b0;
            map_req      <= 1'b0;
            map_col_addr <= '0;
            map_row_addr <= '0;
            pos_col      <= 10'(START_COL);
            pos_row      <= 9'(START_ROW);
            busy         <= 1'b0;
            move_done    <= 1'b0;
            goal_reached <= 1'b0;
        end else begin
            move_done    <= 1'b0;
            goal_reached <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_tick && !r_locked) begin
                        r_cand_col <= w_cand_col[9:0];
                        r_cand_row <= w_cand_row[8:0];
                        r_y_ok     <= w_y_ok;
                        r_goal_hit <= 1'b0;
                        busy       <= 1'b1;
                        if (w_x_ok) begin
                            r_state      <= ST_REQ_X;
                            map_req      <= 1'b1;
                            map_col_addr <= w_cand_col[9:0];
                            map_row_addr <= pos_row;
                        end else if (w_y_ok) begin
                            r_state      <= ST_REQ_Y;
                            map_req      <= 1'b1;
                            map_col_addr <= pos_col;
                            map_row_addr <= w_cand_row[8:0];
                        end else begin
                            r_state   <= ST_DONE;
                            move_done <= 1'b1;
                        end
                    end
                end
                ST_REQ_X: begin
                    if (map_gnt) begin
                        r_state <= ST_WAIT_X;
                        map_req <= 1'b0;
                    end
                end
                ST_WAIT_X: begin
                    if (w_accept) pos_col <= r_cand_col;
                    if (w_is_goal) r_goal_hit <= 1'b1;
                    // Y lookup uses the column just resolved so the ball slides along walls.
                    if (r_y_ok) begin
                        r_state      <= ST_REQ_Y;
                        map_req      <= 1'b1;
                        map_col_addr <= w_col_next;
                        map_row_addr <= r_cand_row;
                    end else begin
                        r_state      <= ST_DONE;
                        move_done    <= 1'b1;
                        goal_reached <= w_is_goal;
                    end
                end
                ST_REQ_Y: begin
                    if (map_gnt) begin
                        r_state <= ST_WAIT_Y;
                        map_req <= 1'b0;
                    end
                end
                ST_WAIT_Y: begin
                    if (w_accept) pos_row <= r_cand_row;
                    r_state      <= ST_DONE;
                    move_done    <= 1'b1;
                    goal_reached <= r_goal_hit | w_is_goal;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                    if (goal_reached) r_locked <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                    map_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
